// File: rtl/bcd_letter_encoder.sv
// Two-digit decimal key entry to 5-bit letter code, with BCD echo and idle timeout.
// Optional build macro BCD_AUTO_COMMIT_EN commits automatically when the second digit arrives.
`timescale 1ns/1ps
module bcd_letter_encoder #(
   parameter int unsigned MAX_CODE       = 26,
   parameter int unsigned TIMEOUT_CYCLES = 100000000,
   parameter int unsigned CNT_W          = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit_in,
   input  logic       digit_stb,
   input  logic       enter_stb,
   input  logic       clear_stb,
   output logic [4:0] code_out,
   output logic       code_valid,
   output logic       err,
   output logic [3:0] tens_bcd,
   output logic [3:0] units_bcd,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONE  = 2'd1,
      TWO  = 2'd2
   } state_t;

   localparam logic [6:0]       MaxValue  = 7'(MAX_CODE);
   localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit               TimeoutOn = (TIMEOUT_CYCLES != 0);

   state_t           state_q, state_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       units_q, units_d;
   logic [4:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             digitOk;
   logic             anyStb;
   logic             timeoutHit;
   logic [6:0]       entryValue;
   logic             commitReq;
   logic [6:0]       commitValue;

   assign digitOk    = (digit_in <= 4'd9);
   assign anyStb     = clear_stb | enter_stb | digit_stb;
   assign timeoutHit = TimeoutOn && (state_q != IDLE) && (cnt_q == CntLast);
   assign entryValue = {3'b000, tens_q} * 7'd10 + {3'b000, units_q};

   // Strobe priority is clear > enter > digit; the idle timeout only acts in a strobe-free cycle.
   always_comb begin
      state_d     = state_q;
      tens_d      = tens_q;
      units_d     = units_q;
      code_d      = code_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      cnt_d       = (TimeoutOn && (state_q != IDLE)) ? cnt_q + CNT_W'(1) : '0;
      commitReq   = 1'b0;
      commitValue = entryValue;

      if (clear_stb) begin
         state_d = IDLE;
         tens_d  = '0;
         units_d = '0;
      end else if (enter_stb) begin
         if (state_q == IDLE) begin
            err_d = 1'b1;
         end else begin
            commitReq = 1'b1;
         end
      end else if (digit_stb) begin
         if (!digitOk) begin
            err_d = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  units_d = digit_in;
                  state_d = ONE;
                  cnt_d   = '0;
               end
               ONE: begin
`ifdef BCD_AUTO_COMMIT_EN
                  commitReq   = 1'b1;
                  commitValue = {3'b000, units_q} * 7'd10 + {3'b000, digit_in};
`else
                  tens_d  = units_q;
                  units_d = digit_in;
                  state_d = TWO;
                  cnt_d   = '0;
`endif
               end
               default: begin
                  err_d = 1'b1;
               end
            endcase
         end
      end else if (timeoutHit) begin
         state_d = IDLE;
         tens_d  = '0;
         units_d = '0;
      end

      // A strobe landing on the expiry cycle wins, so the count starts over.
      if (timeoutHit && anyStb) begin
         cnt_d = '0;
      end

      if (commitReq) begin
         if (commitValue <= MaxValue) begin
            code_d  = commitValue[4:0];
            valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
         state_d = IDLE;
         tens_d  = '0;
         units_d = '0;
      end

      if (state_d == IDLE) begin
         cnt_d = '0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tens_q  <= '0;
         units_q <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tens_q  <= tens_d;
         units_q <= units_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign code_out   = code_q;
   assign code_valid = valid_q;
   assign err        = err_q;
   assign tens_bcd   = tens_q;
   assign units_bcd  = units_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_bcd_letter_encoder.sv
// Self-checking bench for bcd_letter_encoder: directed vector table, hand-written
// reset/timeout sequences, then random strobes against a digit-list reference model.
`timescale 1ns/1ps
module tb_bcd_letter_encoder;

   localparam int MaxCode = 26;
   localparam int Timeout = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] digit_in = 4'd0;
   logic       digit_stb = 1'b0;
   logic       enter_stb = 1'b0;
   logic       clear_stb = 1'b0;
   logic [4:0] code_out;
   logic       code_valid;
   logic       err;
   logic [3:0] tens_bcd;
   logic [3:0] units_bcd;
   logic       busy;

   always #5 clk = ~clk;

   bcd_letter_encoder #(
      .MAX_CODE(MaxCode),
      .TIMEOUT_CYCLES(Timeout),
      .CNT_W(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .digit_in(digit_in),
      .digit_stb(digit_stb),
      .enter_stb(enter_stb),
      .clear_stb(clear_stb),
      .code_out(code_out),
      .code_valid(code_valid),
      .err(err),
      .tens_bcd(tens_bcd),
      .units_bcd(units_bcd),
      .busy(busy)
   );

   typedef struct {
      bit         clr;
      bit         ent;
      bit         dstb;
      logic [3:0] d;
      logic [4:0] code;
      bit         valid;
      bit         errE;
      logic [3:0] tens;
      logic [3:0] units;
      bit         busyE;
   } vec_t;

   vec_t vecs[$];
   int   checksTotal = 0;
   int   checksPassed = 0;

   // Reference model: the entry is just the list of digits typed so far.
   int         mDigits[$];
   int         mQuiet;
   logic [4:0] mCode;
   bit         mValid;
   bit         mErr;

   function automatic void modelReset();
      mDigits.delete();
      mQuiet = 0;
      mCode  = 5'd0;
      mValid = 1'b0;
      mErr   = 1'b0;
   endfunction

   function automatic void modelCommit();
      int v = 0;
      foreach (mDigits[i]) v = v * 10 + mDigits[i];
      if (v <= MaxCode) begin
         mCode  = 5'(v);
         mValid = 1'b1;
      end else begin
         mErr = 1'b1;
      end
      mDigits.delete();
   endfunction

   function automatic void modelStep(input bit clr, input bit ent, input bit dstb, input int d);
      bit expiring = (mDigits.size() > 0) && (mQuiet == Timeout - 1);
      bit accepted = 1'b0;
      mValid = 1'b0;
      mErr   = 1'b0;
      if (clr) begin
         mDigits.delete();
      end else if (ent) begin
         if (mDigits.size() == 0) mErr = 1'b1;
         else modelCommit();
      end else if (dstb) begin
         if (d > 9 || mDigits.size() == 2) begin
            mErr = 1'b1;
         end else begin
            mDigits.push_back(d);
            accepted = 1'b1;
`ifdef BCD_AUTO_COMMIT_EN
            if (mDigits.size() == 2) modelCommit();
`endif
         end
      end else if (expiring) begin
         mDigits.delete();
      end
      if (mDigits.size() == 0 || accepted || (expiring && (clr || ent || dstb))) mQuiet = 0;
      else mQuiet++;
   endfunction

   task automatic checkOutput(input string name, input logic [4:0] eCode, input bit eValid,
                              input bit eErr, input logic [3:0] eTens, input logic [3:0] eUnits,
                              input bit eBusy);
      logic [15:0] got;
      logic [15:0] exp;
      got = {code_out, code_valid, err, tens_bcd, units_bcd, busy};
      exp = {eCode, eValid, eErr, eTens, eUnits, eBusy};
      checksTotal++;
      if (got === exp) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s @%0t: got code=%0d valid=%b err=%b tens=%0d units=%0d busy=%b, expected code=%0d valid=%b err=%b tens=%0d units=%0d busy=%b",
                  name, $time, code_out, code_valid, err, tens_bcd, units_bcd, busy,
                  eCode, eValid, eErr, eTens, eUnits, eBusy);
      end
   endtask

   task automatic checkModel(input string name);
      int n = mDigits.size();
      logic [3:0] eTens  = (n == 2) ? 4'(mDigits[0]) : 4'd0;
      logic [3:0] eUnits = (n >= 1) ? 4'(mDigits[n-1]) : 4'd0;
      checkOutput(name, mCode, mValid, mErr, eTens, eUnits, n > 0);
   endtask

   // One clock cycle of stimulus; outputs are settled 1 ns after the edge on return.
   task automatic applyStimulus(input bit clr, input bit ent, input bit dstb, input int d);
      clear_stb = clr;
      enter_stb = ent;
      digit_stb = dstb;
      digit_in  = 4'(d);
      @(posedge clk);
      #1;
      modelStep(clr, ent, dstb, d);
      clear_stb = 1'b0;
      enter_stb = 1'b0;
      digit_stb = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic addVec(input bit clr, input bit ent, input bit dstb, input int d,
                         input int code, input bit valid, input bit errE,
                         input int tens, input int units, input bit busyE);
      vec_t v;
      v.clr = clr; v.ent = ent; v.dstb = dstb; v.d = 4'(d);
      v.code = 5'(code); v.valid = valid; v.errE = errE;
      v.tens = 4'(tens); v.units = 4'(units); v.busyE = busyE;
      vecs.push_back(v);
   endtask

   initial begin
      //     clr ent dstb d   code v  e  tens units busy
`ifdef BCD_AUTO_COMMIT_EN
      addVec(0, 0, 1, 2,    0, 0, 0, 0, 2, 1);
      addVec(0, 0, 1, 6,   26, 1, 0, 0, 0, 0);
      addVec(0, 0, 0, 0,   26, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 9,   26, 0, 0, 0, 9, 1);
      addVec(0, 0, 1, 9,   26, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 5,   26, 0, 0, 0, 5, 1);
      addVec(0, 0, 1, 10,  26, 0, 1, 0, 5, 1);
      addVec(0, 1, 0, 0,    5, 1, 0, 0, 0, 0);
      addVec(0, 1, 0, 0,    5, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 3,    5, 0, 0, 0, 3, 1);
      addVec(1, 0, 1, 4,    5, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 1,    5, 0, 0, 0, 1, 1);
      addVec(0, 0, 1, 2,   12, 1, 0, 0, 0, 0);
`else
      addVec(0, 0, 1, 1,    0, 0, 0, 0, 1, 1);
      addVec(0, 0, 1, 9,    0, 0, 0, 1, 9, 1);
      addVec(0, 1, 0, 0,   19, 1, 0, 0, 0, 0);
      addVec(0, 0, 0, 0,   19, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 2,   19, 0, 0, 0, 2, 1);
      addVec(0, 0, 1, 7,   19, 0, 0, 2, 7, 1);
      addVec(0, 1, 0, 0,   19, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 3,   19, 0, 0, 0, 3, 1);
      addVec(0, 0, 1, 0,   19, 0, 0, 3, 0, 1);
      addVec(0, 1, 0, 0,   19, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 4,   19, 0, 0, 0, 4, 1);
      addVec(0, 0, 1, 10,  19, 0, 1, 0, 4, 1);
      addVec(1, 0, 0, 0,   19, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 5,   19, 0, 0, 0, 5, 1);
      addVec(0, 1, 0, 0,    5, 1, 0, 0, 0, 0);
      addVec(0, 1, 0, 0,    5, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 2,    5, 0, 0, 0, 2, 1);
      addVec(0, 0, 1, 6,    5, 0, 0, 2, 6, 1);
      addVec(0, 0, 1, 8,    5, 0, 1, 2, 6, 1);
      addVec(0, 1, 0, 0,   26, 1, 0, 0, 0, 0);
      addVec(1, 0, 1, 3,   26, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 1,   26, 0, 0, 0, 1, 1);
      addVec(1, 1, 1, 9,   26, 0, 0, 0, 0, 0);
      addVec(0, 0, 1, 1,   26, 0, 0, 0, 1, 1);
      addVec(0, 1, 1, 2,    1, 1, 0, 0, 0, 0);
      addVec(0, 1, 1, 10,   1, 0, 1, 0, 0, 0);
      addVec(0, 0, 1, 0,    1, 0, 0, 0, 0, 1);
      addVec(0, 1, 0, 0,    0, 1, 0, 0, 0, 0);
      addVec(0, 0, 1, 1,    0, 0, 0, 0, 1, 1);
      addVec(0, 0, 1, 2,    0, 0, 0, 1, 2, 1);
      addVec(0, 1, 0, 0,   12, 1, 0, 0, 0, 0);
`endif

      doReset();
      checkOutput("resetState", 5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].clr, vecs[i].ent, vecs[i].dstb, int'(vecs[i].d));
         checkOutput($sformatf("vec%0d", i), vecs[i].code, vecs[i].valid, vecs[i].errE,
                     vecs[i].tens, vecs[i].units, vecs[i].busyE);
      end

      // Asynchronous reset in the middle of an entry, well away from any clock edge.
      applyStimulus(0, 0, 1, 7);
      checkModel("preReset");
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncReset", 5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Partial entry left idle expires silently after Timeout quiet cycles.
      applyStimulus(0, 0, 1, 4);
      repeat (14) applyStimulus(0, 0, 0, 0);
      checkOutput("timeoutHold", 5'd0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b1);
      repeat (2) applyStimulus(0, 0, 0, 0);
      checkOutput("timeoutExpire", 5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

      // A rejected digit on the expiry cycle wins over the timeout and restarts the count.
      applyStimulus(0, 0, 1, 4);
      repeat (15) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 12);
      checkOutput("timeoutStrobe", 5'd0, 1'b0, 1'b1, 4'd0, 4'd4, 1'b1);
      repeat (14) applyStimulus(0, 0, 0, 0);
      checkOutput("timeoutRestart", 5'd0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b1);
      applyStimulus(1, 0, 0, 0);
      checkOutput("clearIdle", 5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         bit clr  = ($urandom_range(0, 99) < 3);
         bit ent  = ($urandom_range(0, 99) < 9);
         bit dstb = ($urandom_range(0, 99) < 30);
         int d    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                                : int'($urandom_range(0, 9));
         applyStimulus(clr, ent, dstb, d);
         checkModel("random");
         if ($urandom_range(0, 99) < 2) begin
            for (int k = 0; k < 20; k++) begin
               applyStimulus(0, 0, 0, 0);
               checkModel("randomQuiet");
            end
         end
      end

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
